hazard_fwd_unit: RTL and testbench
==================================

Name: hazard_fwd_unit

Overview:
- Pipeline hazard and forwarding controller for the 5-stage RV32I core.
- Consumes the ID-stage decode outputs: hazard_optype, rs1use, rs2use, register addresses and taken-branch.
- Tracks each instruction's hazard class and destination register through EX, MEM and WB in its own shadow pipeline.
- Drives ID-stage operand forwarding selects, MEM-stage store-data forwarding, load-use stall and control-flow flush.

Parameters:
- REG_AW, 5, register address width
- OPT_W, 2, hazard_optype width

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- rs1use_ID  in  1  ID instruction reads rs1
- rs2use_ID  in  1  ID instruction reads rs2
- rs1_ID  in  5  inst[19:15] in ID
- rs2_ID  in  5  inst[24:20] in ID
- rd_ID  in  5  inst[11:7] in ID
- optype_ID  in  2  00 none, 01 ALU-writer, 10 load, 11 store
- Branch_ID  in  1  taken branch/jump resolved in ID
- forward_ctrl_A  out  2  ID rs1 operand select
- forward_ctrl_B  out  2  ID rs2 operand select
- forward_ctrl_ls  out  1  MEM store data comes from WB load data
- stall_PC  out  1  hold PC
- stall_FD  out  1  hold IF/ID register
- flush_FD  out  1  clear IF/ID register
- flush_DE  out  1  insert bubble into ID/EX register

Behaviour:
- Shadow stages EX, MEM, WB; each holds optype[1:0], rd[4:0] and rs2[4:0] (rs2 needed for store forwarding).
- Reset (async, rst=1): all shadow fields become 0.
  - All outputs then derive from the ID inputs only; with ID inputs idle, every output is 0.
- Every rising clk:
  - WB <= MEM and MEM <= EX.
  - EX <= ID fields, or all-zero bubble when stall_PC=1.
  - rs2 is captured only when optype_ID=11; otherwise 0.
- A stage writes a register iff its optype is 01 or 10 and its rd != 0. Store (11) and none (00) never match.
- forward_ctrl_A, combinational, first match wins:
  - rs1use_ID=0 or rs1_ID=0 -> 00.
  - EX writer, optype 01, rd_EX==rs1_ID -> 01 (EX ALU result).
  - MEM ALU writer, rd_MEM==rs1_ID -> 10 (MEM ALU result).
  - MEM load, rd_MEM==rs1_ID -> 11 (MEM load data).
  - Otherwise -> 00 (register file).
- forward_ctrl_B: same rules using rs2use_ID and rs2_ID.
- The EX-stage load case never forwards; it is resolved by stall.
- The register file writes on the falling edge, so WB->ID forwarding is never needed.
- load_use = optype_EX==10, rd_EX!=0, and either:
  - rs1use_ID and rs1_ID==rd_EX, or
  - rs2use_ID and rs2_ID==rd_EX and optype_ID!=11.
- Store data dependence on a load in EX does not stall; it is served later by forward_ctrl_ls.
- Stall (load_use=1): stall_PC=1, stall_FD=1, flush_DE=1, flush_FD=0.
  - Branch_ID is ignored during stall because its operands are stale.
- forward_ctrl_A/B during stall: computed as normal but don't-care, since EX receives a bubble.
- Control flow: Branch_ID=1 and load_use=0 -> flush_FD=1, and stall_PC=stall_FD=flush_DE=0.
- forward_ctrl_ls = optype_MEM==11, optype_WB==10, rd_WB!=0, rd_WB==rs2_MEM.
- Back-to-back writers to the same rd: the youngest (EX) takes priority over MEM.
- Reset asserted mid-stall clears the EX load immediately. load_use drops in the same cycle, asynchronously.

Decomposition:
- Shared package hazard_pkg holds:
  - HZ_NONE=00, HZ_ALU=01, HZ_LOAD=10, HZ_STORE=11. These must match the decoder's hazard_optype encoding.
  - FWD_REG=00, FWD_EX_ALU=01, FWD_MEM_ALU=10, FWD_MEM_LD=11.
- Sub-module hazard_stage_reg: one shadow stage with async reset and a bubble input. Instantiated three times: EX, MEM, WB.

Test Plan:
- Reset: rst=1 mid-run with a load in EX -> all shadow fields 0 and all outputs 0 immediately. After release, idle ID inputs keep outputs 0.
- EX forward: cycle 0 addi x5 (optype 01, rd 5); cycle 1 add x6,x5,x5 (rs1=rs2=5) -> forward_ctrl_A=01 and forward_ctrl_B=01, no stall.
- MEM priority and load forward:
  - lw x7 (rd 7), then nop, then add x8,x7,x0 -> forward_ctrl_A=11 in cycle 2.
  - addi x7, then addi x7, then use x7 -> forward_ctrl_A=01, with EX beating MEM.
- Load-use stall:
  - lw x3, then immediately beq x3,x0 with Branch_ID=1 -> one cycle of stall_PC=stall_FD=flush_DE=1 and flush_FD=0.
  - Next cycle: forward_ctrl_A=11, and flush_FD=1 if Branch_ID is still 1.
- Store after load: lw x9, then sw x9,0(x1) (rs2=9, optype 11) -> no stall; forward_ctrl_ls=1 exactly two cycles later, when the sw is in MEM and the lw is in WB.
- x0 guard: lw x0, then add x1,x0,x0 -> no stall, forward_ctrl_A=B=00.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding unit.
// Encodings track the decoder's hazard_optype.
package hazard_pkg;

  localparam int REG_AW = 5;
  localparam int OPT_W  = 2;

  typedef enum logic [OPT_W-1:0] {
    HZ_NONE  = 2'b00,
    HZ_ALU   = 2'b01,
    HZ_LOAD  = 2'b10,
    HZ_STORE = 2'b11
  } hz_op_t;

  typedef enum logic [1:0] {
    FWD_REG     = 2'b00,
    FWD_EX_ALU  = 2'b01,
    FWD_MEM_ALU = 2'b10,
    FWD_MEM_LD  = 2'b11
  } fwd_t;

  typedef struct packed {
    hz_op_t            optype;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs2;
  } stage_t;

  // Stores and bubbles never produce a register value.
  function automatic logic writes_rd(stage_t s);
    return (s.optype == HZ_ALU || s.optype == HZ_LOAD)
        && (s.rd != '0);
  endfunction

  // Youngest producer wins; a load still in EX is left to the stall.
  function automatic fwd_t fwd_sel(
    logic              use_rs,
    logic [REG_AW-1:0] rs,
    stage_t            ex,
    stage_t            mem
  );
    fwd_t sel;
    sel = FWD_REG;
    if (!use_rs || rs == '0)
      sel = FWD_REG;
    else if (ex.optype == HZ_ALU && ex.rd == rs)
      sel = FWD_EX_ALU;
    else if (writes_rd(mem) && mem.rd == rs)
      sel = (mem.optype == HZ_ALU) ? FWD_MEM_ALU
                                   : FWD_MEM_LD;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// ID-stage decode inputs and hazard control outputs.
// master = decode/pipeline side, slave = hazard unit.
interface hazard_fwd_unit_if;
  import hazard_pkg::*;

  logic              rs1use_ID;
  logic              rs2use_ID;
  logic [REG_AW-1:0] rs1_ID;
  logic [REG_AW-1:0] rs2_ID;
  logic [REG_AW-1:0] rd_ID;
  logic [OPT_W-1:0]  optype_ID;
  logic              Branch_ID;
  logic [1:0]        forward_ctrl_A;
  logic [1:0]        forward_ctrl_B;
  logic              forward_ctrl_ls;
  logic              stall_PC;
  logic              stall_FD;
  logic              flush_FD;
  logic              flush_DE;

  modport master (
    output rs1use_ID, rs2use_ID,
    output rs1_ID, rs2_ID, rd_ID,
    output optype_ID, Branch_ID,
    input  forward_ctrl_A, forward_ctrl_B,
    input  forward_ctrl_ls,
    input  stall_PC, stall_FD,
    input  flush_FD, flush_DE
  );

  modport slave (
    input  rs1use_ID, rs2use_ID,
    input  rs1_ID, rs2_ID, rd_ID,
    input  optype_ID, Branch_ID,
    output forward_ctrl_A, forward_ctrl_B,
    output forward_ctrl_ls,
    output stall_PC, stall_FD,
    output flush_FD, flush_DE
  );

endinterface

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline stage: hazard class, rd, store rs2.
// bubble loads an all-zero (no hazard) entry.
module hazard_stage_reg
  import hazard_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   bubble,
  input  stage_t d,
  output stage_t q
);

  // Advance one stage, or insert a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (bubble)
      q <= '0;
    else
      q <= d;
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Load-use stall, flush and forwarding control
// for the 5-stage RV32I pipeline.
module hazard_fwd_unit
  import hazard_pkg::*;
(
  input logic              clk,
  input logic              rst,
  hazard_fwd_unit_if.slave hz
);

  stage_t id_s;
  stage_t ex_q;
  stage_t mem_q;
  stage_t wb_q;
  logic   load_use;
  logic   rs1_hit;
  logic   rs2_hit;

  // Pack the ID instruction; rs2 only matters for stores.
  always_comb begin
    id_s        = '0;
    id_s.optype = hz_op_t'(hz.optype_ID);
    id_s.rd     = hz.rd_ID;
    if (id_s.optype == HZ_STORE)
      id_s.rs2 = hz.rs2_ID;
  end

  hazard_stage_reg u_ex (
    .clk    (clk),
    .rst    (rst),
    .bubble (load_use),
    .d      (id_s),
    .q      (ex_q)
  );

  hazard_stage_reg u_mem (
    .clk    (clk),
    .rst    (rst),
    .bubble (1'b0),
    .d      (ex_q),
    .q      (mem_q)
  );

  hazard_stage_reg u_wb (
    .clk    (clk),
    .rst    (rst),
    .bubble (1'b0),
    .d      (mem_q),
    .q      (wb_q)
  );

  // Load in EX feeding ID; store data is served later instead.
  always_comb begin
    rs1_hit  = hz.rs1use_ID && (hz.rs1_ID == ex_q.rd);
    rs2_hit  = hz.rs2use_ID && (hz.rs2_ID == ex_q.rd)
            && (id_s.optype != HZ_STORE);
    load_use = (ex_q.optype == HZ_LOAD)
            && (ex_q.rd != '0)
            && (rs1_hit || rs2_hit);
  end

  // Operand selects, stall/flush and store-data forward.
  always_comb begin
    hz.forward_ctrl_A = fwd_sel(hz.rs1use_ID, hz.rs1_ID,
                                ex_q, mem_q);
    hz.forward_ctrl_B = fwd_sel(hz.rs2use_ID, hz.rs2_ID,
                                ex_q, mem_q);
    hz.stall_PC = load_use;
    hz.stall_FD = load_use;
    hz.flush_DE = load_use;
    hz.flush_FD = hz.Branch_ID && !load_use;
    hz.forward_ctrl_ls = (mem_q.optype == HZ_STORE)
                      && (wb_q.optype == HZ_LOAD)
                      && (wb_q.rd != '0)
                      && (wb_q.rd == mem_q.rs2);
  end

  logic unused_wb_rs2;
  assign unused_wb_rs2 = ^wb_q.rs2;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit with an
// instruction-history model and per-row literal expectations.
module tb_hazard_fwd_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit_if hz ();

  hazard_fwd_unit dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  // History of issued instructions: 0 = EX, 1 = MEM, 2 = WB.
  int h_op[3];
  int h_rd[3];
  int h_rs2[3];

  typedef struct {
    bit u1; bit u2; int r1; int r2; int rd; int op; bit br;
    int ea; int eb; bit es; bit ef; bit el;
  } vec_t;

  vec_t vq[$];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit m_writes(int i);
    return (h_op[i] == 1 || h_op[i] == 2) && h_rd[i] != 0;
  endfunction

  function automatic int m_fwd(bit u, int rs);
    if (!u || rs == 0) return 0;
    if (h_op[0] == 1 && h_rd[0] == rs) return 1;
    if (m_writes(1) && h_rd[1] == rs)
      return (h_op[1] == 1) ? 2 : 3;
    return 0;
  endfunction

  function automatic bit m_lu();
    if (h_op[0] != 2 || h_rd[0] == 0) return 0;
    if (hz.rs1use_ID && hz.rs1_ID == h_rd[0]) return 1;
    if (hz.rs2use_ID && hz.rs2_ID == h_rd[0]
        && hz.optype_ID != 3) return 1;
    return 0;
  endfunction

  function automatic bit m_ls();
    return h_op[1] == 3 && h_op[2] == 2
        && h_rd[2] != 0 && h_rd[2] == h_rs2[1];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        h_op[i] = 0; h_rd[i] = 0; h_rs2[i] = 0;
      end
    end else begin
      bit lu;
      lu = m_lu();
      for (int i = 2; i > 0; i--) begin
        h_op[i] = h_op[i-1];
        h_rd[i] = h_rd[i-1];
        h_rs2[i] = h_rs2[i-1];
      end
      h_op[0] = lu ? 0 : int'(hz.optype_ID);
      h_rd[0] = lu ? 0 : int'(hz.rd_ID);
      h_rs2[0] = (!lu && hz.optype_ID == 2'd3)
               ? int'(hz.rs2_ID) : 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      bit lu;
      lu = m_lu();
      chk("model_A", int'(hz.forward_ctrl_A),
          m_fwd(hz.rs1use_ID, int'(hz.rs1_ID)));
      chk("model_B", int'(hz.forward_ctrl_B),
          m_fwd(hz.rs2use_ID, int'(hz.rs2_ID)));
      chk("model_stall_PC", int'(hz.stall_PC), int'(lu));
      chk("model_stall_FD", int'(hz.stall_FD), int'(lu));
      chk("model_flush_DE", int'(hz.flush_DE), int'(lu));
      chk("model_flush_FD", int'(hz.flush_FD),
          int'(hz.Branch_ID && !lu));
      chk("model_ls", int'(hz.forward_ctrl_ls), int'(m_ls()));
    end
  end

  task automatic add(bit u1, bit u2, int r1, int r2, int rd,
                     int op, bit br, int ea, int eb,
                     bit es, bit ef, bit el);
    vec_t v;
    v = '{u1, u2, r1, r2, rd, op, br, ea, eb, es, ef, el};
    vq.push_back(v);
  endtask

  task automatic drive(vec_t v);
    hz.rs1use_ID = v.u1;
    hz.rs2use_ID = v.u2;
    hz.rs1_ID    = 5'(v.r1);
    hz.rs2_ID    = 5'(v.r2);
    hz.rd_ID     = 5'(v.rd);
    hz.optype_ID = 2'(v.op);
    hz.Branch_ID = v.br;
  endtask

  function automatic logic [8:0] outs();
    return {hz.forward_ctrl_A, hz.forward_ctrl_B,
            hz.stall_PC, hz.stall_FD, hz.flush_DE,
            hz.flush_FD, hz.forward_ctrl_ls};
  endfunction

  task automatic run_row(int idx);
    vec_t v;
    logic [8:0] exp;
    v = vq[idx];
    drive(v);
    @(negedge clk);
    #1;
    exp = {2'(v.ea), 2'(v.eb), v.es, v.es, v.es, v.ef, v.el};
    chk($sformatf("row%0d", idx), int'(outs()), int'(exp));
  endtask

  initial begin
    vec_t idle;
    idle = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    drive(idle);
    // u1 u2 rs1 rs2 rd op br | A B stall flushFD ls
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // 0 idle
    add(1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0); // 1 addi x5
    add(1, 1, 5, 5, 6, 1, 0, 1, 1, 0, 0, 0); // 2 add x6,x5,x5
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // 3 nop
    add(1, 0, 2, 0, 7, 2, 0, 0, 0, 0, 0, 0); // 4 lw x7
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // 5 nop
    add(1, 1, 7, 0, 8, 1, 0, 3, 0, 0, 0, 0); // 6 add x8,x7,x0
    add(1, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0); // 7 addi x7
    add(1, 0, 7, 0, 7, 1, 0, 1, 0, 0, 0, 0); // 8 addi x7,x7
    add(1, 1, 7, 7, 10, 1, 0, 1, 1, 0, 0, 0); // 9 EX beats MEM
    add(1, 0, 1, 0, 3, 2, 0, 0, 0, 0, 0, 0); // 10 lw x3
    add(1, 1, 3, 0, 0, 0, 1, 0, 0, 1, 0, 0); // 11 beq stall
    add(1, 1, 3, 0, 0, 0, 1, 3, 0, 0, 1, 0); // 12 beq again
    add(1, 0, 1, 0, 9, 2, 0, 0, 0, 0, 0, 0); // 13 lw x9
    add(1, 1, 1, 9, 0, 3, 0, 0, 0, 0, 0, 0); // 14 sw x9
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // 15 nop
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); // 16 ls fires
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // 17 nop
    add(1, 0, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0); // 18 lw x0
    add(1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0); // 19 add x1,x0,x0
    add(1, 0, 1, 0, 4, 2, 0, 1, 0, 0, 0, 0); // 20 lw x4,0(x1)
    add(1, 1, 4, 0, 5, 1, 0, 0, 0, 1, 0, 0); // 21 add stalls
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // 22 idle
    add(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 0); // 23 jal x1
    add(1, 0, 1, 0, 2, 1, 0, 1, 0, 0, 0, 0); // 24 add x2,x1
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // 25 idle

    repeat (2) @(posedge clk);
    #1;
    chk("reset_idle", int'(outs()), 0);
    rst = 1'b0;

    for (int i = 0; i <= 21; i++) begin
      run_row(i);
      if (i < 21) begin
        @(posedge clk);
        #1;
      end
    end

    rst = 1'b1;
    #1;
    chk("rst_midstall", int'(outs()), 0);
    drive(idle);
    @(posedge clk);
    #1;
    chk("rst_held_idle", int'(outs()), 0);
    rst = 1'b0;

    for (int i = 22; i < vq.size(); i++) begin
      run_row(i);
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
